// File: rtl/stopwatch_time_counter.sv
// Stopwatch time accumulator: counts rising edges of the 100 Hz tick into six
// BCD digits (MM:SS.cc), with lap freeze, clear and a sticky overflow flag.
module stopwatch_time_counter #(
  parameter int unsigned MAX_MIN = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] cs_ones,
  output logic [3:0] cs_tens,
  output logic [3:0] s_ones,
  output logic [3:0] s_tens,
  output logic [3:0] m_ones,
  output logic [3:0] m_tens,
  output logic       hold,
  output logic       overflow
);
  localparam int unsigned NDIG = 6;
  localparam logic [3:0] MAX_MT = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_MO = 4'(MAX_MIN % 10);
  // Per-digit wrap limit, index 0 = cs_ones .. 4 = m_ones
  localparam logic [4:0][3:0] LIM = {4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

  logic                      tick_q;
  logic [NDIG-1:0][3:0]      live_q, live_d, lat_q, lat_d, disp;
  logic                      hold_q, hold_d, ovf_q, ovf_d;
  logic                      inc, at_max;
  logic [NDIG-1:0]           at_lim, cy;

  assign inc = tick_in & ~tick_q;

  for (genvar i = 0; i < 5; i++) begin : g_lim
    assign at_lim[i] = (live_q[i] == LIM[i]);
  end
  // m_tens never wraps on its own; the full wrap at MAX_MIN covers it
  assign at_lim[5] = 1'b0;

  assign cy = {inc & (&at_lim[4:0]), inc & (&at_lim[3:0]), inc & (&at_lim[2:0]),
               inc & (&at_lim[1:0]), inc & at_lim[0], inc};

  assign at_max = cy[4] & (live_q[5] == MAX_MT) & (live_q[4] == MAX_MO);

  always_comb begin
    live_d = live_q;
    lat_d  = lat_q;
    hold_d = hold_q;
    ovf_d  = ovf_q;
    if (clear) begin
      live_d = '0;
      lat_d  = '0;
      hold_d = 1'b0;
      ovf_d  = 1'b0;
    end else begin
      // Latch takes live_q, so a lap coinciding with inc captures the pre-increment time
      if (lap) begin
        if (!hold_q) begin
          lat_d  = live_q;
          hold_d = 1'b1;
        end else begin
          hold_d = 1'b0;
        end
      end
      if (at_max) begin
        live_d = '0;
        ovf_d  = 1'b1;
      end else begin
        for (int i = 0; i < NDIG; i++) begin
          if (cy[i]) live_d[i] = at_lim[i] ? 4'd0 : live_q[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q <= 1'b1;
      live_q <= '0;
      lat_q  <= '0;
      hold_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      tick_q <= tick_in;
      live_q <= live_d;
      lat_q  <= lat_d;
      hold_q <= hold_d;
      ovf_q  <= ovf_d;
    end
  end

  assign disp     = hold_q ? lat_q : live_q;
  assign cs_ones  = disp[0];
  assign cs_tens  = disp[1];
  assign s_ones   = disp[2];
  assign s_tens   = disp[3];
  assign m_ones   = disp[4];
  assign m_tens   = disp[5];
  assign hold     = hold_q;
  assign overflow = ovf_q;
endmodule

// File: doc/stopwatch_time_counter.md
# stopwatch_time_counter

Stopwatch timekeeping stage that consumes the 100 Hz gated square wave produced by the stopwatch clock divider and accumulates elapsed time as six BCD digits (MM:SS.cc). It sits between the divider and the seven-segment display driver. It supports clear, a lap-hold display freeze and a sticky overflow flag. All logic runs in the system clock domain; the 100 Hz input is treated as a level sampled on `clk`, never as a clock.

## Interface

Parameters:
- MAX_MIN, default 59: highest minute value before wrap-around; legal range 1..99.

Ports:
- clk  input  1  system clock (50 MHz).
- rst  input  1  asynchronous, active-high reset.
- tick_in  input  1  100 Hz square wave from the divider, synchronous to `clk`; held constant while the stopwatch is stopped.
- clear  input  1  synchronous clear, level-sensitive.
- lap  input  1  single-cycle lap pulse, already debounced.
- cs_ones, cs_tens  output  4 each  displayed centiseconds, BCD.
- s_ones, s_tens  output  4 each  displayed seconds, BCD, 00..59.
- m_ones, m_tens  output  4 each  displayed minutes, BCD, 00..MAX_MIN.
- hold  output  1  1 while the display is frozen on a lap value.
- overflow  output  1  sticky; set on wrap past MAX_MIN:59.99.

## Operation

- Edge detect: register `tick_d` <= `tick_in` every cycle. `inc = tick_in & ~tick_d`. Exactly one increment per rising edge of `tick_in`. A stopped (constant) `tick_in` produces no increments.
- Live counter: six 4-bit BCD registers. On `inc`, cs_ones increments.
  - Each digit wraps to 0 and carries into the next digit at its limit: cs 9/9, s_ones 9, s_tens 5, m_ones 9.
  - Minutes wrap as a two-digit value at MAX_MIN.
  - Digits never hold a non-BCD value.
- Wrap: on `inc` at MAX_MIN:59.99 (e.g. 59:59.99), all digits go to 00:00.00 and `overflow` is set to 1. `overflow` stays 1 until `clear` or `rst`.
- Lap/hold:
  - `lap` while `hold`=0: copy the live digits into a latch and set `hold`=1.
  - `lap` while `hold`=1: set `hold`=0.
  - The live counter keeps running in both cases.
- Outputs: display digits = `hold` ? latch : live. This is a combinational mux of registered values.
- Clear: the live counter, latch, `hold` and `overflow` all go to 0.
- Priority in one cycle: `clear` > `lap` / `inc`. With `clear`=1, `inc` and `lap` are ignored.
- `lap` and `inc` in the same cycle: the latch captures the pre-increment value, and the live counter increments.

## Timing

- Reset values:
  - All six digit outputs 0.
  - `hold` 0, `overflow` 0.
  - Latch 0.
  - `tick_d` resets to 1, so a `tick_in` already high at reset release is not counted.
- Increment latency: the live digits update on the same `clk` edge that first samples `tick_in`=1 with `tick_d`=0. Display outputs reflect the new value immediately after that edge when `hold`=0.
- Lap latency: `hold` and the latch update on the edge sampling `lap`=1. The display freezes from that edge.
- Clear latency: all outputs read zero after the first edge sampling `clear`=1. Holding `clear` high keeps them zero.
- `rst` asserted mid-count forces the reset values immediately, independent of `clk`.
- Throughput: one increment per `tick_in` rising edge (nominally every 500000 cycles). The logic must also handle increments as often as every 2 cycles, for simulation with a fast `tick_in`.

## Test plan

- Reset/no-count: hold `tick_in`=1 through `rst` release, then keep it at 1 for 100 cycles -> all digits 0, `overflow`=0.
- Cascade: apply 6000 `tick_in` rising edges (toggle every 4 cycles) -> display 01:00.00. After 99 edges -> 00:00.99; after edge 100 -> 00:01.00.
- Wrap: MAX_MIN=59, drive to 59:59.99, apply one more edge -> 00:00.00 and `overflow`=1. Repeat with MAX_MIN=5: after 05:59.99 the next edge gives 00:00.00.
- Lap: run to 00:12.34, pulse `lap` on the same cycle as an `inc` -> display frozen at 00:12.34, `hold`=1. Apply 10 more edges -> display still 00:12.34. Pulse `lap` again -> display 00:12.45, `hold`=0.
- Clear priority: at 00:03.07 with `hold`=1 and `overflow`=1, assert `clear`, `lap` and `inc` together -> next cycle all digits 0, `hold`=0, `overflow`=0.
- Async reset mid-run: assert `rst` between clock edges at 00:45.50 -> outputs 0 before the next `clk` edge. Counting resumes from 00:00.01 at the first edge after release.
